// File: rtl/param_cmd_decoder.sv
// param_cmd_decoder
// Parses 5-byte host frames (HEADER, CMD, DATA_H, DATA_L, CHK) from the link
// receiver. Each valid frame updates one *_data_async word and then raises the
// matching *_ack strobe for ACK_WIDTH cycles. The data word always settles at
// least one cycle before its ack rises, so the consumer can synchronise the ack
// and then sample the data safely.
module param_cmd_decoder #(
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int unsigned ACK_WIDTH = 8,
    parameter logic [15:0] TIMEOUT   = 16'd10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        machine_start_ack,
    output logic        machine_stop_ack,
    output logic        change_Ton_ack,
    output logic [15:0] Ton_data_async,
    output logic        change_Toff_ack,
    output logic [15:0] Toff_data_async,
    output logic        change_Ip_ack,
    output logic [15:0] Ip_data_async,
    output logic        change_waveform_ack,
    output logic [15:0] waveform_data_async,
    output logic        frame_ok,
    output logic        frame_err
);

    localparam int HOLD_W = (ACK_WIDTH > 1) ? $clog2(ACK_WIDTH) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACK_WIDTH - 1);
    localparam logic [15:0] IDLE_LAST = TIMEOUT - 16'd1;

    localparam logic [7:0] CMD_START    = 8'h01;
    localparam logic [7:0] CMD_STOP     = 8'h02;
    localparam logic [7:0] CMD_TON      = 8'h10;
    localparam logic [7:0] CMD_TOFF     = 8'h11;
    localparam logic [7:0] CMD_IP       = 8'h12;
    localparam logic [7:0] CMD_WAVEFORM = 8'h13;

    // Bit positions inside the one-hot ack vector
    localparam int A_START = 0;
    localparam int A_STOP  = 1;
    localparam int A_TON   = 2;
    localparam int A_TOFF  = 3;
    localparam int A_IP    = 4;
    localparam int A_WAVE  = 5;

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_DH,
        S_DL,
        S_CHK,
        S_ISSUE,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]        cmd_q;
    logic [7:0]        dh_q;
    logic [7:0]        dl_q;
    logic [15:0]       idle_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [5:0]        ack_sel;
    logic [5:0]        ack_q;
    logic              cmd_known;
    logic              accept;
    logic              in_frame;
    logic              timeout_hit;
    logic              chk_good;
    logic              err_next;

    // Decode the stored command byte into its one-hot ack target
    always_comb begin
        ack_sel   = 6'b0;
        cmd_known = 1'b0;
        case (cmd_q)
            CMD_START:    begin ack_sel[A_START] = 1'b1; cmd_known = 1'b1; end
            CMD_STOP:     begin ack_sel[A_STOP]  = 1'b1; cmd_known = 1'b1; end
            CMD_TON:      begin ack_sel[A_TON]   = 1'b1; cmd_known = 1'b1; end
            CMD_TOFF:     begin ack_sel[A_TOFF]  = 1'b1; cmd_known = 1'b1; end
            CMD_IP:       begin ack_sel[A_IP]    = 1'b1; cmd_known = 1'b1; end
            CMD_WAVEFORM: begin ack_sel[A_WAVE]  = 1'b1; cmd_known = 1'b1; end
            default:      begin ack_sel = 6'b0; cmd_known = 1'b0; end
        endcase
    end

    // Handshake, frame-window and checksum qualifiers shared by the FSM and datapath
    always_comb begin
        rx_ready    = !((state == S_ISSUE) || (state == S_HOLD));
        accept      = rx_valid && rx_ready;
        in_frame    = (state == S_CMD) || (state == S_DH) ||
                      (state == S_DL)  || (state == S_CHK);
        timeout_hit = in_frame && (idle_cnt == IDLE_LAST);
        chk_good    = (rx_data == (cmd_q ^ dh_q ^ dl_q)) && cmd_known;
    end

    // Next-state logic; a timeout wins over a byte arriving on the same edge
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            S_HUNT: begin
                if (accept && (rx_data == HEADER)) begin
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (timeout_hit) begin
                    state_next = S_HUNT;
                    err_next   = 1'b1;
                end else if (accept) begin
                    state_next = S_DH;
                end
            end
            S_DH: begin
                if (timeout_hit) begin
                    state_next = S_HUNT;
                    err_next   = 1'b1;
                end else if (accept) begin
                    state_next = S_DL;
                end
            end
            S_DL: begin
                if (timeout_hit) begin
                    state_next = S_HUNT;
                    err_next   = 1'b1;
                end else if (accept) begin
                    state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (timeout_hit) begin
                    state_next = S_HUNT;
                    err_next   = 1'b1;
                end else if (accept) begin
                    if (chk_good) begin
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_HUNT;
                        err_next   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = S_HUNT;
                end
            end
            default: begin
                state_next = S_HUNT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Capture the command and data bytes as they are accepted inside a frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q <= 8'h00;
            dh_q  <= 8'h00;
            dl_q  <= 8'h00;
        end else if (accept && !timeout_hit) begin
            case (state)
                S_CMD:   cmd_q <= rx_data;
                S_DH:    dh_q  <= rx_data;
                S_DL:    dl_q  <= rx_data;
                default: ;
            endcase
        end
    end

    // Inter-byte idle counter; only meaningful while a frame is being collected
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= 16'd0;
        end else if (!in_frame || accept || timeout_hit) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // Counts the cycles spent in HOLD so the ack lasts exactly ACK_WIDTH cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if ((state == S_HOLD) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Parameter words are written once in ISSUE and otherwise hold their value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Ton_data_async      <= 16'h0000;
            Toff_data_async     <= 16'h0000;
            Ip_data_async       <= 16'h0000;
            waveform_data_async <= 16'h0000;
        end else if (state == S_ISSUE) begin
            case (cmd_q)
                CMD_TON:      Ton_data_async      <= {dh_q, dl_q};
                CMD_TOFF:     Toff_data_async     <= {dh_q, dl_q};
                CMD_IP:       Ip_data_async       <= {dh_q, dl_q};
                CMD_WAVEFORM: waveform_data_async <= {dh_q, dl_q};
                default:      ;
            endcase
        end
    end

    // Registered strobes: acks trail HOLD by one edge so data leads them by a cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q     <= 6'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ack_q     <= (state == S_HOLD) ? ack_sel : 6'b0;
            frame_ok  <= (state == S_HOLD) && (hold_cnt == '0);
            frame_err <= err_next;
        end
    end

    assign machine_start_ack   = ack_q[A_START];
    assign machine_stop_ack    = ack_q[A_STOP];
    assign change_Ton_ack      = ack_q[A_TON];
    assign change_Toff_ack     = ack_q[A_TOFF];
    assign change_Ip_ack       = ack_q[A_IP];
    assign change_waveform_ack = ack_q[A_WAVE];

endmodule

// File: tb/tb_param_cmd_decoder.sv
// tb_param_cmd_decoder
// Directed frames are driven from one initial block; each frame pushes its
// expected outcome (ack kind + data, or an error) onto a queue, and a negedge
// monitor pops and checks it when the DUT raises an ack or frame_err.
module tb_param_cmd_decoder;

    localparam int ACK_W = 8;
    localparam logic [2:0] KIND_ERR = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        machine_start_ack;
    logic        machine_stop_ack;
    logic        change_Ton_ack;
    logic [15:0] Ton_data_async;
    logic        change_Toff_ack;
    logic [15:0] Toff_data_async;
    logic        change_Ip_ack;
    logic [15:0] Ip_data_async;
    logic        change_waveform_ack;
    logic [15:0] waveform_data_async;
    logic        frame_ok;
    logic        frame_err;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    logic [15:0] m_ton  = 16'h0;
    logic [15:0] m_toff = 16'h0;
    logic [15:0] m_ip   = 16'h0;
    logic [15:0] m_wave = 16'h0;

    param_cmd_decoder #(
        .HEADER    (8'hA5),
        .ACK_WIDTH (ACK_W),
        .TIMEOUT   (16'd10000)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .machine_start_ack   (machine_start_ack),
        .machine_stop_ack    (machine_stop_ack),
        .change_Ton_ack      (change_Ton_ack),
        .Ton_data_async      (Ton_data_async),
        .change_Toff_ack     (change_Toff_ack),
        .Toff_data_async     (Toff_data_async),
        .change_Ip_ack       (change_Ip_ack),
        .Ip_data_async       (Ip_data_async),
        .change_waveform_ack (change_waveform_ack),
        .waveform_data_async (waveform_data_async),
        .frame_ok            (frame_ok),
        .frame_err           (frame_err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] all_acks();
        return {change_waveform_ack, change_Ip_ack, change_Toff_ack,
                change_Ton_ack, machine_stop_ack, machine_start_ack};
    endfunction

    function automatic logic [15:0] data_of(input logic [2:0] kind);
        case (kind)
            3'd2:    return Ton_data_async;
            3'd3:    return Toff_data_async;
            3'd4:    return Ip_data_async;
            3'd5:    return waveform_data_async;
            default: return 16'h0;
        endcase
    endfunction

    // Offers one byte starting just after a posedge; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) checkOutput("rx_ready_stall", rx_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Drives a full frame and queues the outcome a correct decoder must produce
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] dh,
                                 input logic [7:0] dl, input logic [7:0] chk,
                                 input bit keep_valid);
        bit   good;
        exp_t e;
        good = (chk == (cmd ^ dh ^ dl));
        e.data = {dh, dl};
        case (cmd)
            8'h01:   e.kind = 3'd0;
            8'h02:   e.kind = 3'd1;
            8'h10:   e.kind = 3'd2;
            8'h11:   e.kind = 3'd3;
            8'h12:   e.kind = 3'd4;
            8'h13:   e.kind = 3'd5;
            default: begin e.kind = KIND_ERR; good = 1'b0; end
        endcase
        if (!good) begin
            e.kind = KIND_ERR;
        end else begin
            case (e.kind)
                3'd2:    m_ton  = e.data;
                3'd3:    m_toff = e.data;
                3'd4:    m_ip   = e.data;
                3'd5:    m_wave = e.data;
                default: ;
            endcase
        end
        exp_q.push_back(e);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(dh);
        send_byte(dl);
        send_byte(chk);
        if (!keep_valid) rx_valid = 1'b0;
    endtask

    // Lets outstanding events retire and the ack finish before the next step
    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !rx_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", exp_q.size(), 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        checkOutput({tag, "_ton"},  Ton_data_async,      m_ton);
        checkOutput({tag, "_toff"}, Toff_data_async,     m_toff);
        checkOutput({tag, "_ip"},   Ip_data_async,       m_ip);
        checkOutput({tag, "_wave"}, waveform_data_async, m_wave);
    endtask

    logic [5:0]  cur_acks;
    logic [5:0]  prev_acks  = 6'b0;
    logic        prev_err   = 1'b0;
    logic        prev_ready = 1'b1;
    logic        rising;
    int          ack_run    = 0;
    int          ready_run  = 0;
    bit          ack_rst    = 1'b0;
    bit          ready_rst  = 1'b0;
    logic [15:0] prev_data [6];
    exp_t        mon_e;

    initial begin
        for (int i = 0; i < 6; i++) prev_data[i] = 16'h0;
    end

    // Scoreboard monitor: pops the queue on each ack rise or frame_err pulse
    always @(negedge clk) begin
        if (mon_en) begin
            cur_acks = all_acks();
            rising   = (prev_acks == 6'b0) && (cur_acks != 6'b0);
            if (!$onehot0(cur_acks)) checkOutput("ack_onehot", cur_acks, 6'b0);
            if ((prev_acks != 6'b0) && (cur_acks == 6'b0) && !ack_rst)
                checkOutput("ack_width", ack_run, ACK_W);
            if (rising) begin
                ack_run = 0;
                ack_rst = 1'b0;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ack", cur_acks, 6'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("ack_kind", cur_acks, 6'b1 << mon_e.kind);
                    checkOutput("frame_ok_first", frame_ok, 1'b1);
                    if (mon_e.kind >= 3'd2 && mon_e.kind <= 3'd5) begin
                        checkOutput("data_value", data_of(mon_e.kind), mon_e.data);
                        checkOutput("data_lead", prev_data[mon_e.kind], mon_e.data);
                    end
                end
            end
            if (frame_ok) checkOutput("frame_ok_align", rising, 1'b1);
            if (cur_acks != 6'b0) ack_run++;
            if (frame_err && !prev_err) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_err", frame_err, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("err_kind", mon_e.kind, KIND_ERR);
                end
            end
            if (frame_err && prev_err) checkOutput("frame_err_pulse", prev_err, 1'b0);
            if (!prev_ready && rx_ready && !ready_rst)
                checkOutput("rx_ready_low", ready_run, 1 + ACK_W);
            if (!rx_ready) begin
                if (prev_ready) begin
                    ready_run = 0;
                    ready_rst = 1'b0;
                end
                ready_run++;
            end
            if (!rst_n) begin
                ack_rst   = 1'b1;
                ready_rst = 1'b1;
            end
            prev_acks  = cur_acks;
            prev_err   = frame_err;
            prev_ready = rx_ready;
            prev_data[2] = Ton_data_async;
            prev_data[3] = Toff_data_async;
            prev_data[4] = Ip_data_async;
            prev_data[5] = waveform_data_async;
        end
    end

    int tmo_k;
    bit tmo_seen;
    int wait_n;

    // Directed test sequence
    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rx_ready", rx_ready, 1'b1);
        checkOutput("reset_acks", all_acks(), 6'b0);
        checkOutput("reset_pulses", {frame_ok, frame_err}, 2'b00);
        check_model("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        $display("[TB] step 1: Ton frame");
        applyStimulus(8'h10, 8'h00, 8'h64, 8'h74, 1'b0);
        wait_drain();
        checkOutput("t1_ton", Ton_data_async, 16'h0064);

        $display("[TB] step 2: start and stop frames");
        applyStimulus(8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
        wait_drain();
        check_model("t2_start");
        applyStimulus(8'h02, 8'h00, 8'h00, 8'h02, 1'b0);
        wait_drain();
        check_model("t2_stop");

        $display("[TB] step 3: header value as data, bad checksum, unknown cmd");
        applyStimulus(8'h12, 8'hA5, 8'h00, 8'hB7, 1'b0);
        wait_drain();
        checkOutput("t3_ip_hdr_data", Ip_data_async, 16'hA500);
        applyStimulus(8'h12, 8'h00, 8'h32, 8'h21, 1'b0);
        wait_drain();
        checkOutput("t3_ip_kept", Ip_data_async, 16'hA500);
        applyStimulus(8'h7F, 8'h00, 8'h00, 8'h7F, 1'b0);
        wait_drain();
        check_model("t3_unknown");

        $display("[TB] step 4: garbage then waveform frame");
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        rx_valid = 1'b0;
        applyStimulus(8'h13, 8'h00, 8'h01, 8'h12, 1'b0);
        wait_drain();
        checkOutput("t4_wave", waveform_data_async, 16'h0001);

        $display("[TB] step 5: timeout mid-frame");
        exp_q.push_back('{kind: KIND_ERR, data: 16'h0});
        send_byte(8'hA5);
        send_byte(8'h11);
        rx_valid = 1'b0;
        tmo_k    = 0;
        tmo_seen = 1'b0;
        while (!tmo_seen && tmo_k < 10200) begin
            @(negedge clk);
            tmo_k++;
            tmo_seen = frame_err;
        end
        checkOutput("t5_timeout_cycles", tmo_k, 10001);
        wait_drain();
        applyStimulus(8'h11, 8'h01, 8'hF4, 8'hE4, 1'b0);
        wait_drain();
        checkOutput("t5_toff", Toff_data_async, 16'h01F4);

        $display("[TB] step 6: back-to-back frames, then reset during hold");
        applyStimulus(8'h12, 8'h00, 8'h32, 8'h20, 1'b1);
        applyStimulus(8'h13, 8'h12, 8'h34, 8'h35, 1'b0);
        wait_drain();
        check_model("t6_b2b");
        applyStimulus(8'h10, 8'h12, 8'h34, 8'h36, 1'b0);
        wait_n = 0;
        while (!change_Ton_ack && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        checkOutput("t6_ack_seen", change_Ton_ack, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        m_ton  = 16'h0;
        m_toff = 16'h0;
        m_ip   = 16'h0;
        m_wave = 16'h0;
        checkOutput("t6_rst_acks", all_acks(), 6'b0);
        checkOutput("t6_rst_ready", rx_ready, 1'b1);
        check_model("t6_rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
